// File: rtl/grey_seq_ctrl_if.sv
// Control and index bus between the Gray index sequencer and its driver.
// The slave modport belongs to grey_seq_ctrl; the master modport belongs to whatever drives it.
interface grey_seq_ctrl_if;
  logic       start;
  logic       stop;
  logic       dir;
  logic       wrap;
  logic       step_req;
  logic       step_ack;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] idx;
  logic       valid;
  logic       busy;
  logic       tc;
  logic       done;
  logic [1:0] state_dbg;

  // Step handshake is four-phase. The master raises step_req. The slave advances once and raises step_ack.
  // step_ack stays high until step_req is seen low, and then the slave drops step_ack.
  // valid is a one-cycle strobe that qualifies a new idx value and has no back-pressure.
  modport master (
    output start, stop, dir, wrap, step_req, load, load_val,
    input  step_ack, idx, valid, busy, tc, done, state_dbg
  );

  modport slave (
    input  start, stop, dir, wrap, step_req, load, load_val,
    output step_ack, idx, valid, busy, tc, done, state_dbg
  );
endinterface

// File: rtl/grey_seq_ctrl.sv
// Index sequencer for the Gray-code mapper: free-run, single-step, up/down, wrap/stop, and parallel load.
// Optional `GREY_SEQ_PRESCALE_EN slows RUN-mode advances to one every PRESCALE clocks.
module grey_seq_ctrl #(
  parameter logic [3:0] START    = 4'd0,
  parameter int         PRESCALE = 4
) (
  input logic            clk,
  input logic            rst,
  grey_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       ack_q, ack_d;
  logic       valid_q, valid_d;
  logic       force_valid;
  logic       tc;
  logic [3:0] adv_idx;
  logic       run_tick;

  assign tc = bus.dir ? (idx_q == 4'd0) : (idx_q == 4'd15);

  // An advance saturates at the end value when wrap is off.
  always_comb begin
    adv_idx = idx_q;
    if (bus.wrap || !tc) begin
      adv_idx = bus.dir ? (idx_q - 4'd1) : (idx_q + 4'd1);
    end
  end

`ifdef GREY_SEQ_PRESCALE_EN
  logic [3:0] pre_q, pre_d;
  logic       pre_clr;

  assign run_tick = (pre_q == 4'(PRESCALE - 1));
  assign pre_clr  = bus.load || bus.stop || ((state_q != S_RUN) && (state_d == S_RUN));

  always_comb begin
    pre_d = pre_q;
    if (pre_clr) begin
      pre_d = 4'd0;
    end else if (state_q == S_RUN) begin
      pre_d = run_tick ? 4'd0 : (pre_q + 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= 4'd0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign run_tick        = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ack_d       = ack_q;
    force_valid = 1'b0;
    if (bus.load) begin
      idx_d       = bus.load_val;
      state_d     = S_IDLE;
      ack_d       = 1'b0;
      force_valid = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // stop outranks start, so asserting both together leaves the FSM in IDLE.
          if (bus.stop) begin
            state_d = S_IDLE;
          end else if (bus.start) begin
            state_d = S_RUN;
          end else if (bus.step_req) begin
            idx_d   = adv_idx;
            ack_d   = 1'b1;
            state_d = S_STEP;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else if (run_tick) begin
            if (!bus.wrap && tc) begin
              state_d = S_DONE;
            end else begin
              idx_d = adv_idx;
            end
          end
        end
        S_STEP: begin
          if (!bus.step_req) begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_DONE: begin
          // A restart reloads the starting end value, so valid is forced even when idx already holds it.
          if (!bus.stop && bus.start) begin
            idx_d       = bus.dir ? 4'd15 : 4'd0;
            state_d     = S_RUN;
            force_valid = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    valid_d = force_valid || (idx_d != idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= START;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  assign bus.idx       = idx_q;
  assign bus.valid     = valid_q;
  assign bus.step_ack  = ack_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_STEP);
  assign bus.done      = (state_q == S_DONE);
  assign bus.tc        = tc;
  assign bus.state_dbg = state_q;

endmodule
